// File: rtl/core_pkg.sv
// Shared encodings, ALU codes, FSM states and decode bundle for the
// multi-cycle RISC-V sequencer.
package core_pkg;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_SYS = 7'h73;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_cause_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alu_src_imm;
    logic [3:0]  alu_control;
  } dec_t;

  localparam dec_t DEC_RST = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0,
                               alu_src_imm: 1'b0, alu_control: ALU_NOP};

endpackage

// File: rtl/inst_decode.sv
// Combinational decoder for the supported subset: ADD, SUB, ADDI, ECALL.
module inst_decode
  import core_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec,
  output logic        is_ecall,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    dec             = DEC_RST;
    dec.rs1         = instr[19:15];
    dec.rs2         = instr[24:20];
    dec.rd          = instr[11:7];
    is_ecall        = 1'b0;
    illegal         = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct3 == 3'd0 && funct7 == 7'h00)      dec.alu_control = ALU_ADD;
        else if (funct3 == 3'd0 && funct7 == 7'h20) dec.alu_control = ALU_SUB;
        else                                        illegal = 1'b1;
      end
      OP_I: begin
        if (funct3 == 3'd0) begin
          dec.alu_control = ALU_ADD;
          dec.alu_src_imm = 1'b1;
          dec.imm         = {{20{instr[31]}}, instr[31:20]};
        end else begin
          illegal = 1'b1;
        end
      end
      OP_SYS: begin
        if (instr == 32'h0000_0073) is_ecall = 1'b1;
        else                        illegal  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with sticky HALT on
// ECALL, illegal encoding or instruction-fetch timeout.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rs1_num,
  output logic [4:0]  rs2_num,
  output logic [4:0]  rd_num,
  output logic [31:0] imm,
  output logic        alu_src_imm,
  output logic [3:0]  alu_control,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  error
);

  localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(FETCH_TIMEOUT - 1);

  seq_state_t    state_q, state_d;
  logic [31:0]   pc_q, pc_d, instr_q, instr_d, instret_q, instret_d;
  logic [CW-1:0] wait_q, wait_d;
  dec_t          dec_q, dec_d, dec_w;
  logic          rf_we_q, rf_we_d, halted_q, halted_d;
  err_cause_t    error_q, error_d;
  logic          is_ecall, illegal;

  inst_decode u_dec (
    .instr    (instr_q),
    .dec      (dec_w),
    .is_ecall (is_ecall),
    .illegal  (illegal)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    wait_d    = wait_q;
    dec_d     = dec_q;
    rf_we_d   = 1'b0;
    halted_d  = halted_q;
    error_d   = error_q;
    case (state_q)
      S_FETCH: begin
        // Data arriving on the last allowed cycle still beats the timeout.
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          error_d  = ERR_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        dec_d = dec_w;
        if (illegal) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          error_d  = ERR_ILLEGAL;
        end else if (is_ecall) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          error_d  = ERR_NONE;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        rf_we_d = (dec_q.rd != 5'd0);
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_d      = pc_q + 32'd4;
        instret_d = instret_q + 32'd1;
        wait_d    = '0;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
      wait_q    <= '0;
      dec_q     <= DEC_RST;
      rf_we_q   <= 1'b0;
      halted_q  <= 1'b0;
      error_q   <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
      dec_q     <= dec_d;
      rf_we_q   <= rf_we_d;
      halted_q  <= halted_d;
      error_q   <= error_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign rs1_num     = dec_q.rs1;
  assign rs2_num     = dec_q.rs2;
  assign rd_num      = dec_q.rd;
  assign imm         = dec_q.imm;
  assign alu_src_imm = dec_q.alu_src_imm;
  assign alu_control = dec_q.alu_control;
  assign rf_we       = rf_we_q;
  assign pc          = pc_q;
  assign instret     = instret_q;
  assign halted      = halted_q;
  assign error       = error_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: drives imem by hand, checks on negedge.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [4:0]  rs1_num, rs2_num, rd_num;
  logic [31:0] imm;
  logic        alu_src_imm;
  logic [3:0]  alu_control;
  logic        rf_we;
  logic [31:0] pc, instret;
  logic        halted;
  logic [1:0]  error;

  int total = 0;
  int bad   = 0;

  core_sequencer #(.RESET_PC(32'h0), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .rs1_num(rs1_num), .rs2_num(rs2_num), .rd_num(rd_num), .imm(imm),
    .alu_src_imm(alu_src_imm), .alu_control(alu_control), .rf_we(rf_we),
    .pc(pc), .instret(instret), .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of FETCH cycle 1.
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Returns at the negedge of the DECODE cycle.
  task automatic fetch(input logic [31:0] instr, input int waits);
    repeat (waits) @(negedge clk);
    imem_valid = 1'b1; imem_rdata = instr;
    @(negedge clk);
    imem_valid = 1'b0; imem_rdata = 32'h0;
  endtask

  task automatic run_instr(input logic [31:0] instr);
    fetch(instr, 0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_valid = 1'b0; imem_rdata = 32'h0;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_error", error, 2'd0);
    chk("rst_alu", alu_control, 4'hF);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_rd", rd_num, 5'd0);
    chk("rst_req", imem_req, 1'b1);
    @(negedge clk); rst = 1'b0;

    // ADDI x1,x0,5 with zero-wait memory
    chk("addi_req", imem_req, 1'b1);
    chk("addi_addr", imem_addr, 32'h0);
    fetch(32'h0050_0093, 0);
    chk("addi_dec_alu_hold", alu_control, 4'hF);
    tick();
    chk("addi_rd", rd_num, 5'd1);
    chk("addi_imm", imm, 32'd5);
    chk("addi_src", alu_src_imm, 1'b1);
    chk("addi_alu", alu_control, 4'b0010);
    chk("addi_we_c3", rf_we, 1'b0);
    tick();
    chk("addi_we_c4", rf_we, 1'b1);
    chk("addi_pc_c4", pc, 32'h0);
    tick();
    chk("addi_we_c5", rf_we, 1'b0);
    chk("addi_pc", pc, 32'h4);
    chk("addi_instret", instret, 32'd1);
    chk("addi_next_addr", imem_addr, 32'h4);

    // SUB x2,x1,x2 with 3 wait cycles: rf_we in cycle 7
    fetch(32'h4020_8133, 3);
    chk("sub_halted", halted, 1'b0);
    tick();
    chk("sub_alu", alu_control, 4'b0100);
    chk("sub_src", alu_src_imm, 1'b0);
    chk("sub_imm", imm, 32'h0);
    chk("sub_rs1", rs1_num, 5'd1);
    chk("sub_rs2", rs2_num, 5'd2);
    chk("sub_rd", rd_num, 5'd2);
    chk("sub_we_c6", rf_we, 1'b0);
    tick();
    chk("sub_we_c7", rf_we, 1'b1);
    tick();
    chk("sub_pc", pc, 32'h8);
    chk("sub_instret", instret, 32'd2);

    // reset asserted during WRITEBACK of addi x3,x0,1
    fetch(32'h0010_0193, 0);
    tick(); tick();
    chk("wbrst_we_before", rf_we, 1'b1);
    rst = 1'b1;
    #1;
    chk("wbrst_we", rf_we, 1'b0);
    chk("wbrst_pc", pc, 32'h0);
    chk("wbrst_instret", instret, 32'h0);
    chk("wbrst_alu", alu_control, 4'hF);
    @(negedge clk); rst = 1'b0;
    chk("wbrst_addr", imem_addr, 32'h0);
    chk("wbrst_req", imem_req, 1'b1);

    // two ADDIs then ECALL
    run_instr(32'h0050_0093);
    run_instr(32'h0050_0093);
    chk("ecall_pre_pc", pc, 32'h8);
    fetch(32'h0000_0073, 0);
    tick();
    chk("ecall_halted", halted, 1'b1);
    chk("ecall_error", error, 2'd0);
    chk("ecall_pc", pc, 32'h8);
    chk("ecall_instret", instret, 32'd2);
    for (int i = 0; i < 20; i++) begin
      imem_valid = i[0];
      imem_rdata = 32'h0050_0093;
      tick();
      chk("ecall_req_low", imem_req, 1'b0);
    end
    imem_valid = 1'b0; imem_rdata = 32'h0;
    chk("ecall_pc_hold", pc, 32'h8);
    chk("ecall_halted_hold", halted, 1'b1);
    chk("ecall_instret_hold", instret, 32'd2);

    // illegal encoding (funct3=1 under OP_R)
    do_reset();
    fetch(32'h0000_1033, 0);
    tick();
    chk("ill_halted", halted, 1'b1);
    chk("ill_error", error, 2'd1);
    chk("ill_alu", alu_control, 4'hF);
    chk("ill_we", rf_we, 1'b0);
    repeat (3) begin
      tick();
      chk("ill_we_later", rf_we, 1'b0);
    end
    chk("ill_instret", instret, 32'd0);
    chk("ill_pc", pc, 32'h0);

    // addi x0,x0,1: no write, still retires; then fetch timeout
    do_reset();
    fetch(32'h0010_0013, 0);
    tick();
    chk("x0_we_c3", rf_we, 1'b0);
    tick();
    chk("x0_we_c4", rf_we, 1'b0);
    tick();
    chk("x0_instret", instret, 32'd1);
    chk("x0_pc", pc, 32'h4);
    repeat (15) tick();
    chk("to_not_yet", halted, 1'b0);
    chk("to_req_c16", imem_req, 1'b1);
    tick();
    chk("to_halted", halted, 1'b1);
    chk("to_error", error, 2'd2);
    chk("to_pc", pc, 32'h4);
    chk("to_instret", instret, 32'd1);
    chk("to_req", imem_req, 1'b0);

    // imem_valid on the 16th FETCH cycle beats the timeout (ADD x3,x1,x2)
    do_reset();
    fetch(32'h0020_81b3, 15);
    chk("race_halted", halted, 1'b0);
    tick();
    chk("race_alu", alu_control, 4'b0010);
    chk("race_src", alu_src_imm, 1'b0);
    chk("race_rd", rd_num, 5'd3);
    tick();
    chk("race_we", rf_we, 1'b1);
    tick();
    chk("race_pc", pc, 32'h4);
    chk("race_instret", instret, 32'd1);
    chk("race_error", error, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle sequencer for the single-issue RISC-V core. It owns the PC, fetches instructions over a request/valid handshake, decodes them, and steps the register-file/ALU datapath through EXECUTE and WRITEBACK one instruction at a time. It halts on ECALL, on an unsupported encoding, or when a fetch times out. It sits between instruction memory and the existing register file and ALU.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- FETCH_TIMEOUT, 16, maximum cycles FETCH waits for imem_valid before an error halt (≥1)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_valid  in  1  instruction data valid
- imem_rdata  in  32  instruction word
- rs1_num  out  5  source register 1 index
- rs2_num  out  5  source register 2 index
- rd_num  out  5  destination register index
- imm  out  32  sign-extended I-type immediate; 0 for R-type
- alu_src_imm  out  1  1 = ALU operand B is imm, 0 = operand B is rs2
- alu_control  out  4  ALU operation code
- rf_we  out  1  register-file write enable, one-cycle pulse
- pc  out  32  current PC
- instret  out  32  count of retired instructions
- halted  out  1  sticky halt flag
- error  out  2  halt cause: 0 = none/ECALL, 1 = illegal instruction, 2 = fetch timeout

## Operation
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- Reset values:
  - state = FETCH, pc = RESET_PC, instr register = 0
  - every decode output = 0, except alu_control = 4'b1111
  - rf_we = 0, instret = 0, halted = 0, error = 0, wait counter = 0
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - When imem_valid = 1: latch imem_rdata into the instr register and go to DECODE.
  - Otherwise increment the wait counter. When the counter reaches FETCH_TIMEOUT, go to HALT with error = 2.
  - The wait counter clears on entry to FETCH.
- DECODE: register the decoder outputs from the instr register. Selection by opcode:
  - 0x33 with funct3=0, funct7=0x00: ADD, alu_control = 4'b0010, alu_src_imm = 0.
  - 0x33 with funct3=0, funct7=0x20: SUB, alu_control = 4'b0100, alu_src_imm = 0.
  - 0x13 with funct3=0: ADDI, alu_control = 4'b0010, alu_src_imm = 1, imm = {{20{i[31]}}, i[31:20]}.
  - 0x73 with instr = 32'h0000_0073: ECALL, go to HALT with error = 0.
  - Anything else: go to HALT with error = 1, alu_control = 4'b1111.
  - Supported instructions go to EXECUTE.
- EXECUTE: hold the decode outputs for one cycle so the ALU can settle. Go to WRITEBACK.
- WRITEBACK:
  - rf_we = 1 for this cycle only; suppressed when rd_num = 0.
  - pc <= pc + 4, with 32-bit wrap (32'hFFFF_FFFC → 0).
  - instret <= instret + 1, with wrap.
  - Go to FETCH.
- HALT:
  - Absorbing until rst.
  - halted = 1; imem_req = 0; rf_we = 0.
  - pc stays at the halting instruction's address.
  - ECALL and illegal instructions do not increment instret.
- imem_valid while imem_req = 0 is ignored.

## Timing
- All outputs are registered, except imem_req and imem_addr, which are decoded from state and pc.
- Zero-wait memory (imem_valid high in the first FETCH cycle): 4 cycles per instruction, rf_we asserted in cycle 4.
- Each wait cycle adds 1. With N wait cycles the latency is N+4.
- A timeout with imem_valid never asserted enters HALT on the FETCH_TIMEOUT-th FETCH cycle, i.e. halted is visible FETCH_TIMEOUT+1 cycles after FETCH entry.
- Decode outputs change only on the DECODE→EXECUTE edge and are stable through WRITEBACK.
- rst asserted mid-instruction (any state, including WRITEBACK): all registers return to their reset values immediately. An in-progress rf_we pulse is dropped. After release the core restarts at RESET_PC.
- When imem_valid and the timeout coincide in the same cycle, imem_valid wins.

## Structure
- core_pkg holds:
  - the opcode constants OP_R = 7'h33, OP_I = 7'h13, OP_SYS = 7'h73
  - the ALU codes ALU_ADD = 4'b0010, ALU_SUB = 4'b0100, ALU_NOP = 4'b1111
  - the state enum seq_state_t
  - the error-cause enum
- Sub-module inst_decode: purely combinational, takes instr[31:0] and returns the field indices, imm, alu_control, alu_src_imm, is_ecall and illegal. Instantiated once.
- The FSM, PC, wait counter and instret stay in core_sequencer.

## Test plan
- ADDI: zero-wait memory, instr 0x00500093 (addi x1,x0,5) → rd=1, imm=5, alu_src_imm=1, alu_control=0010; rf_we pulses in cycle 4; pc 0→4; instret=1.
- SUB with wait states: instr 0x40208133 (sub x2,x1,x2), imem_valid delayed by 3 cycles → alu_control=0100; rf_we in cycle 7; instret increments once.
- ECALL after two ADDIs → halted=1, error=0, pc=8, instret=2, imem_req stays 0 for 20 further cycles.
- Illegal instruction 0x00001033 (funct3=1, unsupported) → HALT, error=1, alu_control=1111, no rf_we pulse.
- FETCH_TIMEOUT=16 with imem_valid held low → halted rises 17 cycles after FETCH entry, error=2; addi x0,x0,1 → no rf_we pulse, instret still increments.
- rst asserted during WRITEBACK → rf_we drops the same cycle; pc=RESET_PC, instret=0; after release, the first fetch is at RESET_PC.
